// File: rtl/store_rmw_unit_pkg.sv
// Shared encodings for the store path: store ops, RMW FSM states and the legality rule.
package store_rmw_unit_pkg;

  localparam int unsigned ST_OP_LENGTH = 2;
  localparam int unsigned LANE_WIDTH   = 2;
  localparam int unsigned WORD_WIDTH   = 32;

  typedef enum logic [ST_OP_LENGTH-1:0] {
    ST_OP_SW  = 2'b00,
    ST_OP_SH  = 2'b01,
    ST_OP_SB  = 2'b10,
    ST_OP_RSV = 2'b11
  } st_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WAIT  = 2'b10,
    ST_WRITE = 2'b11
  } st_state_e;

  // Word stores must be word aligned, halfwords halfword aligned; reserved op is never legal.
  function automatic logic st_legal(input logic [ST_OP_LENGTH-1:0] op,
                                    input logic [LANE_WIDTH-1:0]   lane);
    case (op)
      ST_OP_SW: st_legal = (lane == 2'b00);
      ST_OP_SH: st_legal = ~lane[0];
      ST_OP_SB: st_legal = 1'b1;
      default:  st_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Store request and word-memory signals between datapath, store unit and data memory.
interface store_rmw_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  import store_rmw_unit_pkg::*;

  logic                    st_req;
  logic [ST_OP_LENGTH-1:0] st_op;
  logic [ADDR_WIDTH-1:0]   st_addr;
  logic [WORD_WIDTH-1:0]   st_data;
  logic                    st_err;
  logic                    st_done;
  logic                    stall;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_rd_en;
  logic [WORD_WIDTH-1:0]   mem_rdata;
  logic                    mem_wr_en;
  logic [WORD_WIDTH-1:0]   mem_wdata;

  modport slave (
    input  st_req, st_op, st_addr, st_data, mem_rdata,
    output st_err, st_done, stall, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );

  modport master (
    output st_req, st_op, st_addr, st_data, mem_rdata,
    input  st_err, st_done, stall, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );

endinterface

// File: rtl/store_rmw_unit_store_merge.sv
// Inserts narrowed store data into an existing memory word on little-endian byte lanes.
module store_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [WORD_WIDTH-1:0]   old_word,
  input  logic [WORD_WIDTH-1:0]   st_data,
  input  logic [ST_OP_LENGTH-1:0] op,
  input  logic [LANE_WIDTH-1:0]   lane,
  output logic [WORD_WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_word;
    case (op)
      ST_OP_SW: merged = st_data;
      ST_OP_SH: begin
        if (lane[1]) merged[31:16] = st_data[15:0];
        else         merged[15:0]  = st_data[15:0];
      end
      ST_OP_SB: merged[{lane, 3'b000} +: 8] = st_data[7:0];
      default:  merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit for a byte-enable-less word memory: SW writes directly, SB/SH go through read-modify-write.
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  store_rmw_unit_if.slave  bus
);

  st_state_e               state_q, state_d;
  logic [ST_OP_LENGTH-1:0] op_q, op_d;
  logic [LANE_WIDTH-1:0]   lane_q, lane_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic                    done_q, done_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic                    stall_c;
  logic                    legal_c;
  logic [DATA_WIDTH-1:0]   merged_c;

  assign legal_c = st_legal(bus.st_op, bus.st_addr[1:0]);

  store_merge u_merge (
    .old_word (bus.mem_rdata),
    .st_data  (data_q),
    .op       (op_q),
    .lane     (lane_q),
    .merged   (merged_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= ST_OP_SW;
      lane_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Strobes are computed one cycle ahead so they leave the unit registered in the state that owns them.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lane_d  = lane_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.st_req) begin
          if (!legal_c) begin
            err_d = 1'b1;
          end else begin
            stall_c = 1'b1;
            op_d    = bus.st_op;
            lane_d  = bus.st_addr[1:0];
            data_d  = bus.st_data;
            addr_d  = {bus.st_addr[ADDR_WIDTH-1:2], 2'b00};
            if (bus.st_op == ST_OP_SW) begin
              wdata_d = bus.st_data;
              wr_d    = 1'b1;
              done_d  = 1'b1;
              state_d = ST_WRITE;
            end else begin
              rd_d    = 1'b1;
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        stall_c = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        wdata_d = merged_c;
        wr_d    = 1'b1;
        done_d  = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.st_err    = err_q;
  assign bus.st_done   = done_q;
  assign bus.stall     = stall_c;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd_en = rd_q;
  assign bus.mem_wr_en = wr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed and random stores against a byte-level reference memory model.
module tb_store_rmw_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;
  int   done_total = 0;

  store_rmw_unit_if #(.ADDR_WIDTH(32)) bus ();

  store_rmw_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory responder: the memory the DUT actually talks to.
  logic [31:0] mem     [int unsigned];
  // Reference model: what memory should contain after each store.
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] mem_rd(input int unsigned widx);
    if (mem.exists(widx)) return mem[widx];
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned widx);
    if (ref_mem.exists(widx)) return ref_mem[widx];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem_rd(bus.mem_addr >> 2);
    if (bus.mem_wr_en) mem[bus.mem_addr >> 2] = bus.mem_wdata;
    if (bus.st_done)   done_total++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input int op, input logic [31:0] addr);
    if (op == 3) return 1'b0;
    if (op == 0) return (addr % 4) == 0;
    if (op == 1) return (addr % 2) == 0;
    return 1'b1;
  endfunction

  // Byte-array view of the word: replace the addressed bytes, keep the rest.
  function automatic logic [31:0] model_merge(input logic [31:0] old, input int op,
                                              input logic [31:0] addr, input logic [31:0] data);
    logic [7:0]  b [4];
    logic [31:0] res;
    int          k;
    for (int i = 0; i < 4; i++) b[i] = 8'((old >> (8 * i)) & 32'hFF);
    k = int'(addr % 4);
    if (op == 0) return data;
    if (op == 2) b[k] = 8'(data & 32'hFF);
    if (op == 1) begin
      b[k]     = 8'(data & 32'hFF);
      b[k + 1] = 8'((data >> 8) & 32'hFF);
    end
    res = 32'h0;
    for (int i = 0; i < 4; i++) res = res + (32'(b[i]) << (8 * i));
    return res;
  endfunction

  task automatic run_store(input string tag, input int op, input logic [31:0] addr,
                           input logic [31:0] data);
    bit          legal;
    int          stall_cnt, rd_cnt, wr_cnt, err_cnt, done_cnt, both_cnt;
    int          rd_cyc, wr_cyc, err_cyc, done_cyc;
    logic [31:0] rd_addr, wr_addr, wr_data, exp_word;
    legal = model_legal(op, addr);
    exp_word = model_merge(ref_rd(addr >> 2), op, addr, data);
    stall_cnt = 0; rd_cnt = 0; wr_cnt = 0; err_cnt = 0; done_cnt = 0; both_cnt = 0;
    rd_cyc = -1; wr_cyc = -1; err_cyc = -1; done_cyc = -1;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    bus.st_req  = 1'b1;
    bus.st_op   = 2'(op);
    bus.st_addr = addr;
    bus.st_data = data;
    #1;
    if (bus.stall) stall_cnt++;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) bus.st_req = 1'b0;
      #1;
      if (bus.stall) stall_cnt++;
      if (bus.st_err) begin err_cnt++; err_cyc = c; end
      if (bus.st_done) begin done_cnt++; done_cyc = c; end
      if (bus.mem_rd_en) begin rd_cnt++; rd_cyc = c; rd_addr = bus.mem_addr; end
      if (bus.mem_wr_en) begin wr_cnt++; wr_cyc = c; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata; end
      if (bus.mem_rd_en && bus.mem_wr_en) both_cnt++;
    end
    if (legal) ref_mem[addr >> 2] = exp_word;
    chk({tag, " err_cnt"},   32'(err_cnt),   legal ? 32'd0 : 32'd1);
    chk({tag, " stall_cnt"}, 32'(stall_cnt), !legal ? 32'd0 : (op == 0 ? 32'd1 : 32'd3));
    chk({tag, " rd_cnt"},    32'(rd_cnt),    (legal && op != 0) ? 32'd1 : 32'd0);
    chk({tag, " wr_cnt"},    32'(wr_cnt),    legal ? 32'd1 : 32'd0);
    chk({tag, " done_cnt"},  32'(done_cnt),  legal ? 32'd1 : 32'd0);
    chk({tag, " both_strobes"}, 32'(both_cnt), 32'd0);
    if (!legal) chk({tag, " err_cyc"}, 32'(err_cyc), 32'd1);
    if (legal && op != 0) begin
      chk({tag, " rd_cyc"},  32'(rd_cyc), 32'd1);
      chk({tag, " rd_addr"}, rd_addr, addr & ~32'h3);
    end
    if (legal) begin
      chk({tag, " wr_cyc"},   32'(wr_cyc),   op == 0 ? 32'd1 : 32'd3);
      chk({tag, " done_cyc"}, 32'(done_cyc), op == 0 ? 32'd1 : 32'd3);
      chk({tag, " wr_addr"},  wr_addr, addr & ~32'h3);
      chk({tag, " wr_data"},  wr_data, exp_word);
    end
    chk({tag, " mem_word"}, mem_rd(addr >> 2), ref_rd(addr >> 2));
  endtask

  initial begin
    int          done_base;
    int          rop;
    logic [31:0] raddr, rdata, w;
    bus.st_req = 1'b0; bus.st_op = 2'b00; bus.st_addr = '0; bus.st_data = '0;
    mem[32'h200 >> 2] = 32'h11223344; ref_mem[32'h200 >> 2] = 32'h11223344;
    mem[32'h300 >> 2] = 32'h11223344; ref_mem[32'h300 >> 2] = 32'h11223344;
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      mem[(32'h400 >> 2) + i] = w;
      ref_mem[(32'h400 >> 2) + i] = w;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst stall", 32'(bus.stall), 32'd0);
    chk("rst rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("rst wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("rst done",  32'(bus.st_done), 32'd0);
    chk("rst err",   32'(bus.st_err), 32'd0);
    chk("rst addr",  bus.mem_addr, 32'h0);
    chk("rst wdata", bus.mem_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    run_store("sw_100", 0, 32'h100, 32'hDEADBEEF);
    run_store("sb_203", 2, 32'h203, 32'h000000AA);
    chk("sb_203 word", mem_rd(32'h200 >> 2), 32'hAA223344);
    run_store("sh_302", 1, 32'h302, 32'h0000BEEF);
    chk("sh_302 word", mem_rd(32'h300 >> 2), 32'hBEEF3344);
    run_store("sh_301_bad", 1, 32'h301, 32'h12345678);
    run_store("sw_102_bad", 0, 32'h102, 32'h12345678);
    run_store("rsv_bad",    3, 32'h100, 32'h12345678);

    // Reset during the WAIT cycle of an SB drops the store
    bus.st_req = 1'b1; bus.st_op = 2'b10; bus.st_addr = 32'h201; bus.st_data = 32'h55;
    @(posedge clk); #1;
    bus.st_req = 1'b0;
    chk("rstmid rd_en", 32'(bus.mem_rd_en), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstmid wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("rstmid rd_en2", 32'(bus.mem_rd_en), 32'd0);
    chk("rstmid done", 32'(bus.st_done), 32'd0);
    chk("rstmid stall", 32'(bus.stall), 32'd0);
    chk("rstmid addr", bus.mem_addr, 32'h0);
    chk("rstmid wdata", bus.mem_wdata, 32'h0);
    @(posedge clk); #1;
    chk("rstmid wr_late", 32'(bus.mem_wr_en), 32'd0);
    chk("rstmid word", mem_rd(32'h200 >> 2), 32'hAA223344);
    run_store("sw_after_rst", 0, 32'h104, 32'hCAFEF00D);

    // Four SBs building one word lane by lane
    done_base = done_total;
    mem[32'h500 >> 2] = 32'hFFFFFFFF; ref_mem[32'h500 >> 2] = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) run_store("sb_lane", 2, 32'h500 + 32'(k), 32'(k + 1));
    chk("lanes word", mem_rd(32'h500 >> 2), 32'h04030201);
    chk("lanes done", 32'(done_total - done_base), 32'd4);

    // Random stores over a small window so lanes collide often
    for (int n = 0; n < 40; n++) begin
      rop   = int'($urandom_range(0, 3));
      raddr = 32'h400 + 32'($urandom_range(0, 31));
      rdata = $urandom;
      run_store("rand", rop, raddr, rdata);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
